// File: rtl/us_timming_req_driver_mc.sv
// Multi-channel upstream timing request driver: drains one cache FIFO (or emits a simulated
// frame when it is empty) onto a single ready/valid flow through a 2-entry output buffer.
module us_timming_req_driver_mc #(
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_W      = 2,
  parameter int unsigned CNT_W     = 12,
  parameter int unsigned MAX_BURST = 256,
  parameter int unsigned SIM_BEATS = 4,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic                      sys_clk_i,
  input  logic                      rst_i,
  input  logic                      transmit_start_trigger_i,
  input  logic [CH_W-1:0]           ch_sel_i,
  input  logic [23:0]               sim_id_i,
  output logic [NUM_CH-1:0]         us_timming_rd_en_o,
  input  logic [NUM_CH*DATA_W-1:0]  us_timming_dout_i,
  input  logic [NUM_CH-1:0]         us_timming_empty_i,
  input  logic [NUM_CH*CNT_W-1:0]   us_timming_cache_count_i,
  input  logic                      us_timming_flow_rdy_i,
  output logic                      us_timming_flow_vld_o,
  output logic [DATA_W-1:0]         us_timming_flow_o,
  output logic                      us_timming_flow_last_o,
  output logic                      busy_o,
  output logic                      transmit_done_pluse_o,
  output logic                      timeout_o
);

  localparam int unsigned BW   = CNT_W + 1;
  localparam int unsigned TW   = $clog2(TIMEOUT);
  localparam int unsigned HdrW = 104;
  localparam int unsigned PadW = DATA_W - HdrW;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRead = 2'd1;
  localparam logic [1:0] StSim  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [23:0]       sim_id_q, sim_id_d;
  logic [BW-1:0]     len_q, len_d;
  logic [BW-1:0]     issued_q, issued_d;
  logic [BW-1:0]     pushed_q, pushed_d;
  logic              in_flight_q, in_flight_d;
  logic [DATA_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic              last0_q, last0_d, last1_q, last1_d;
  logic [1:0]        occ_q, occ_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              tmo_flag_q, tmo_flag_d;
  logic [15:0]       frame_q, frame_d;

  logic [DATA_W-1:0] sel_data;
  logic              sel_empty;
  logic [CNT_W-1:0]  trig_cnt;
  logic              trig_ch_ok;
  logic              pop, push, push_last, rd_req, starve;
  logic [DATA_W-1:0] push_data, sim_data;
  logic [2:0]        fill;
  logic [HdrW-1:0]   sim_hdr;

  // Per-channel muxing done by loop so out-of-range selects simply match nothing.
  always_comb begin
    sel_data   = '0;
    sel_empty  = 1'b1;
    trig_cnt   = '0;
    trig_ch_ok = 1'b0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (ch_q == CH_W'(k)) begin
        sel_data  = us_timming_dout_i[k*DATA_W +: DATA_W];
        sel_empty = us_timming_empty_i[k];
      end
      if (ch_sel_i == CH_W'(k)) begin
        trig_cnt   = us_timming_cache_count_i[k*CNT_W +: CNT_W];
        trig_ch_ok = 1'b1;
      end
    end
  end

  always_comb begin
    sim_hdr = {32'hFDF7_EB90, 16'(SIM_BEATS * DATA_W / 8), 8'h40, sim_id_q[23:16], 8'h00,
               sim_id_q[15:8], sim_id_q[7:0], frame_q};
    if (pushed_q == '0) begin
      sim_data = {sim_hdr, {PadW{1'b0}}};
    end else begin
      sim_data = {(DATA_W/32){frame_q, 16'(pushed_q)}};
    end
  end

  assign pop = (occ_q != 2'd0) & us_timming_flow_rdy_i;
  // Buffer slots already claimed after this cycle's pop; a new read needs one free.
  assign fill = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
  assign rd_req = (state_q == StRead) & !sel_empty & (issued_q < len_q) & (fill <= 3'd1);
  assign starve = (occ_q == 2'd0) & !in_flight_q & sel_empty;

  always_comb begin
    us_timming_rd_en_o = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      us_timming_rd_en_o[k] = rd_req & (ch_q == CH_W'(k));
    end
  end

  always_comb begin
    push      = 1'b0;
    push_data = sel_data;
    push_last = 1'b0;
    if (state_q == StRead) begin
      push      = in_flight_q;
      push_last = (pushed_q + BW'(1)) == len_q;
    end else if (state_q == StSim) begin
      push      = (pushed_q < BW'(SIM_BEATS)) & ((occ_q != 2'd2) | pop);
      push_data = sim_data;
      push_last = pushed_q == BW'(SIM_BEATS - 1);
    end
  end

  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    occ_d   = occ_q;
    if (pop && push) begin
      if (occ_q == 2'd1) begin
        ent0_d  = push_data;
        last0_d = push_last;
      end else begin
        ent0_d  = ent1_q;
        last0_d = last1_q;
        ent1_d  = push_data;
        last1_d = push_last;
      end
    end else if (pop) begin
      ent0_d  = ent1_q;
      last0_d = last1_q;
      occ_d   = occ_q - 2'd1;
    end else if (push) begin
      if (occ_q == 2'd0) begin
        ent0_d  = push_data;
        last0_d = push_last;
      end else begin
        ent1_d  = push_data;
        last1_d = push_last;
      end
      occ_d = occ_q + 2'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    sim_id_d    = sim_id_q;
    len_d       = len_q;
    issued_d    = issued_q + BW'(rd_req);
    pushed_d    = pushed_q + BW'(push);
    in_flight_d = rd_req;
    tmo_d       = tmo_q;
    tmo_flag_d  = tmo_flag_q;
    frame_d     = frame_q;
    unique case (state_q)
      StIdle: begin
        if (transmit_start_trigger_i) begin
          ch_d       = ch_sel_i;
          sim_id_d   = sim_id_i;
          len_d      = (trig_cnt > CNT_W'(MAX_BURST)) ? BW'(MAX_BURST) : {1'b0, trig_cnt};
          issued_d   = '0;
          pushed_d   = '0;
          tmo_d      = '0;
          tmo_flag_d = 1'b0;
          state_d    = (!trig_ch_ok || trig_cnt == '0) ? StSim : StRead;
        end
      end
      StRead: begin
        if (pop && last0_q) begin
          state_d = StDone;
        end else if (starve) begin
          if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d    = StDone;
            tmo_flag_d = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end else begin
          tmo_d = '0;
        end
      end
      StSim: begin
        if (pop && last0_q) begin
          state_d = StDone;
          frame_d = frame_q + 16'd1;
        end
      end
      default: begin
        state_d    = StIdle;
        tmo_flag_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      sim_id_q    <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      pushed_q    <= '0;
      in_flight_q <= 1'b0;
      ent0_q      <= '0;
      ent1_q      <= '0;
      last0_q     <= 1'b0;
      last1_q     <= 1'b0;
      occ_q       <= 2'd0;
      tmo_q       <= '0;
      tmo_flag_q  <= 1'b0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      sim_id_q    <= sim_id_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      pushed_q    <= pushed_d;
      in_flight_q <= in_flight_d;
      ent0_q      <= ent0_d;
      ent1_q      <= ent1_d;
      last0_q     <= last0_d;
      last1_q     <= last1_d;
      occ_q       <= occ_d;
      tmo_q       <= tmo_d;
      tmo_flag_q  <= tmo_flag_d;
      frame_q     <= frame_d;
    end
  end

  assign us_timming_flow_vld_o  = occ_q != 2'd0;
  assign us_timming_flow_o      = ent0_q;
  assign us_timming_flow_last_o = (occ_q != 2'd0) & last0_q;
  assign busy_o                 = state_q != StIdle;
  assign transmit_done_pluse_o  = state_q == StDone;
  assign timeout_o              = (state_q == StDone) & tmo_flag_q;

endmodule

// File: tb/tb_us_timming_req_driver_mc.sv
// Scoreboard bench for us_timming_req_driver_mc with a behavioural 1-cycle-latency FIFO per channel.
module tb_us_timming_req_driver_mc;

  localparam int DW   = 128;
  localparam int NCH  = 4;
  localparam int CHW  = 2;
  localparam int CW   = 12;
  localparam int MAXB = 256;
  localparam int SIMB = 4;
  localparam int TMO  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              trigger = 1'b0;
  logic [CHW-1:0]    ch_sel = '0;
  logic [23:0]       sim_id = '0;
  logic [NCH-1:0]    rd_en;
  logic [NCH*DW-1:0] dout;
  logic [NCH-1:0]    empty;
  logic [NCH*CW-1:0] cnt;
  logic              rdy = 1'b1;
  logic              vld, last, busy, done, tmo;
  logic [DW-1:0]     flow;

  us_timming_req_driver_mc #(
    .DATA_W(DW), .NUM_CH(NCH), .CH_W(CHW), .CNT_W(CW), .MAX_BURST(MAXB),
    .SIM_BEATS(SIMB), .TIMEOUT(TMO)
  ) dut (
    .sys_clk_i                (clk),
    .rst_i                    (rst),
    .transmit_start_trigger_i (trigger),
    .ch_sel_i                 (ch_sel),
    .sim_id_i                 (sim_id),
    .us_timming_rd_en_o       (rd_en),
    .us_timming_dout_i        (dout),
    .us_timming_empty_i       (empty),
    .us_timming_cache_count_i (cnt),
    .us_timming_flow_rdy_i    (rdy),
    .us_timming_flow_vld_o    (vld),
    .us_timming_flow_o        (flow),
    .us_timming_flow_last_o   (last),
    .busy_o                   (busy),
    .transmit_done_pluse_o    (done),
    .timeout_o                (tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: words written by the stimulus, read with one cycle of latency.
  logic [DW-1:0] mem [NCH][1024];
  int            wr_ptr [NCH];
  int            rd_ptr [NCH];
  logic          cnt_force = 1'b0;
  int            force_ch = 0;
  logic [CW-1:0] force_val = '0;

  always @(posedge clk) begin
    for (int k = 0; k < NCH; k++) begin
      if (rd_en[k]) begin
        dout[k*DW +: DW] <= mem[k][rd_ptr[k] % 1024];
        rd_ptr[k]        <= rd_ptr[k] + 1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      empty[k] = (rd_ptr[k] == wr_ptr[k]);
      cnt[k*CW +: CW] = CW'(wr_ptr[k] - rd_ptr[k]);
      if (cnt_force && force_ch == k) cnt[k*CW +: CW] = force_val;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [DW-1:0] sb_data [$];
  logic          sb_last [$];

  int            rdy_mode = 0;
  int            exp_lat = 3;
  int            exp_gap = 1;
  logic          exp_tmo = 1'b0;
  logic [NCH-1:0] exp_rden = '0;
  logic [15:0]   tb_frame = '0;

  int            trig_cyc, last_hs_cyc, issued, popped;
  int            done_cnt = 0;
  logic          first_pend = 1'b0, prev_stall = 1'b0, prev_done = 1'b0;
  logic [DW-1:0] prev_flow;

  task automatic load(input int ch, input int n, input int n_exp, input int last_idx);
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] d;
      d = {$urandom, $urandom, $urandom, $urandom};
      mem[ch][wr_ptr[ch] % 1024] = d;
      wr_ptr[ch]++;
      if (i < n_exp) begin
        sb_data.push_back(d);
        sb_last.push_back(i == last_idx);
      end
    end
  endtask

  task automatic push_sim(input logic [23:0] id, input logic [15:0] fc);
    logic [DW-1:0] b;
    b = '0;
    b[DW-1 -: 104] = {32'hFDF7_EB90, 16'(SIMB * DW / 8), 8'h40, id[23:16], 8'h00, id[15:8],
                      id[7:0], fc};
    sb_data.push_back(b);
    sb_last.push_back(1'b0);
    for (int k = 1; k < SIMB; k++) begin
      b = {(DW/32){fc, 16'(k)}};
      sb_data.push_back(b);
      sb_last.push_back(k == SIMB - 1);
    end
  endtask

  task automatic trig(input int ch, input logic [23:0] id);
    @(posedge clk);
    #1;
    ch_sel  = CHW'(ch);
    sim_id  = id;
    trigger = 1'b1;
    @(posedge clk);
    #1;
    trigger = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk_eq("done_seen", DW'(done_cnt != start), DW'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_eq({tag, "_vld"}, DW'(vld), '0);
    chk_eq({tag, "_busy"}, DW'(busy), '0);
    chk_eq({tag, "_rd_en"}, DW'(rd_en), '0);
    chk_eq({tag, "_done"}, DW'(done), '0);
    chk_eq({tag, "_timeout"}, DW'(tmo), '0);
    chk_eq({tag, "_flow"}, flow, '0);
    chk_eq({tag, "_last"}, DW'(last), '0);
  endtask

  task automatic mon_step();
    if (rst) begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      first_pend = 1'b0;
      return;
    end
    if (trigger && !busy) begin
      trig_cyc   = cyc;
      first_pend = 1'b1;
      issued     = 0;
      popped     = 0;
    end
    if (vld && first_pend) begin
      chk_eq("first_vld_latency", DW'(cyc - trig_cyc), DW'(exp_lat));
      first_pend = 1'b0;
    end
    if (rd_en != '0) begin
      issued++;
      chk_eq("rd_en_onehot", DW'(rd_en), DW'(exp_rden));
      chk_eq("rd_on_empty", DW'(rd_en & empty), '0);
    end
    if (prev_stall) begin
      chk_eq("stall_vld", DW'(vld), DW'(1));
      chk_eq("stall_data", flow, prev_flow);
    end
    if (vld && rdy) begin
      popped++;
      last_hs_cyc = cyc;
      if (sb_data.size() == 0) begin
        chk_eq("extra_beat", flow, '0);
      end else begin
        chk_eq("beat_data", flow, sb_data.pop_front());
        chk_eq("beat_last", DW'(last), DW'(sb_last.pop_front()));
      end
    end
    if (rd_en != '0) chk_eq("buf_overfill", DW'((issued - popped) <= 2), DW'(1));
    if (done) begin
      done_cnt++;
      chk_eq("done_gap", DW'(cyc - last_hs_cyc), DW'(exp_gap));
      chk_eq("timeout_flag", DW'(tmo), DW'(exp_tmo));
    end else if (tmo) begin
      chk_eq("timeout_without_done", DW'(tmo), '0);
    end
    if (prev_done) chk_eq("busy_after_done", DW'(busy), '0);
    prev_done  = done;
    prev_stall = vld && !rdy;
    prev_flow  = flow;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
      forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = 1'b0;
        endcase
      end
    join_none

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Plain READ of 5 words from channel 1.
    load(1, 5, 5, 4);
    exp_rden = 4'b0010; exp_lat = 3; exp_gap = 1; exp_tmo = 1'b0;
    trig(1, 24'h0);
    wait_done(200);
    chk_eq("t1_beats", DW'(popped), DW'(5));
    chk_eq("t1_sb_empty", DW'(sb_data.size()), '0);

    // Two simulated frames from empty channel 0.
    exp_rden = '0; exp_lat = 2;
    for (int f = 0; f < 2; f++) begin
      push_sim(24'h12_34_56, tb_frame);
      trig(0, 24'h12_34_56);
      wait_done(200);
      tb_frame++;
      chk_eq("sim_sb_empty", DW'(sb_data.size()), '0);
    end

    // Burst cap: 300 words offered, 256 taken.
    load(2, 300, MAXB, MAXB - 1);
    exp_rden = 4'b0100; exp_lat = 3;
    trig(2, 24'h0);
    wait_done(2000);
    chk_eq("cap_beats", DW'(popped), DW'(MAXB));
    chk_eq("cap_left_in_fifo", DW'(wr_ptr[2] - rd_ptr[2]), DW'(300 - MAXB));
    wr_ptr[2] = rd_ptr[2];

    // Random back-pressure plus a trigger while busy.
    load(3, 8, 8, 7);
    exp_rden = 4'b1000;
    rdy_mode = 1;
    trig(3, 24'h0);
    repeat (2) @(posedge clk);
    trig(3, 24'h0);
    wait_done(500);
    rdy_mode = 0;
    chk_eq("bp_sb_empty", DW'(sb_data.size()), '0);
    repeat (3) @(negedge clk);
    chk_eq("bp_retrigger_ignored", DW'(busy), '0);

    // Starved FIFO: count claims 6, only 3 exist.
    load(1, 3, 3, -1);
    exp_rden = 4'b0010; exp_gap = TMO + 1; exp_tmo = 1'b1;
    cnt_force = 1'b1; force_ch = 1; force_val = CW'(6);
    trig(1, 24'h0);
    cnt_force = 1'b0;
    wait_done(TMO + 200);
    chk_eq("tmo_sb_empty", DW'(sb_data.size()), '0);
    exp_gap = 1; exp_tmo = 1'b0;

    // Reset mid-READ under full stall.
    load(2, 10, 0, -1);
    exp_rden = 4'b0100;
    rdy_mode = 2;
    trig(2, 24'h0);
    repeat (5) @(posedge clk);
    begin
      int d0;
      d0 = done_cnt;
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_idle_outputs("midreset");
      repeat (10) @(negedge clk);
      chk_eq("midreset_no_done", DW'(done_cnt), DW'(d0));
    end
    wr_ptr[2] = rd_ptr[2];
    rdy_mode = 0;
    tb_frame = '0;

    // Frame counter restarts from zero after reset.
    exp_rden = '0; exp_lat = 2;
    push_sim(24'hA5_0F_3C, tb_frame);
    trig(0, 24'hA5_0F_3C);
    wait_done(200);
    chk_eq("sim_after_reset_sb_empty", DW'(sb_data.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
